pint_slave: RTL

Chip-side responder for the PINT serial port driven by the ICE controller. Synchronizes the master's PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ and PINT_RESETN into the local clock domain. Decodes write frames into single-cycle register writes. Answers read frames by fetching a register and shifting it back on PINT_RDDATA, framed by PINT_RDRDY.

---
 rtl/pint_slave.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pint_slave.sv
// PINT serial slave: synchronizes the master's port into clk, decodes write
// frames into register write strobes and serves read frames back on RDDATA.
module pint_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              PINT_CLK,
  input  logic              PINT_WRREQ,
  input  logic              PINT_WRDATA,
  input  logic              PINT_RDREQ,
  input  logic              PINT_RESETN,
  output logic              PINT_RDRDY,
  output logic              PINT_RDDATA,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_err
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SHIFT, S_WR_COMMIT, S_RD_ADDR,
    S_RD_FETCH, S_RD_LOAD, S_RD_SHIFT, S_WAIT
  } state_t;

  // bit order in each synchronizer stage: {RESETN, RDREQ, WRDATA, WRREQ, CLK}
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic                        clk_prev_q;
  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [FW-1:0]               sh_q;
  logic [DATA_W-1:0]           out_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [DATA_W-1:0]           wdata_q;
  logic                        wr_en_q, rd_en_q, err_q, rdrdy_q, rddata_q;

  logic          s_clk, s_wr, s_dat, s_rd, s_prst, rise;
  logic [FW-1:0] sh_d;
  logic [CW-1:0] cnt_d;

  assign {s_prst, s_rd, s_dat, s_wr, s_clk} = sync_q[SYNC_STAGES-1];
  assign rise  = s_clk & ~clk_prev_q;
  assign sh_d  = {sh_q[FW-2:0], s_dat};
  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0],
                            {PINT_RESETN, PINT_RDREQ, PINT_WRDATA, PINT_WRREQ, PINT_CLK}};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      out_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
      rdrdy_q    <= 1'b0;
      rddata_q   <= 1'b0;
    end else begin
      clk_prev_q <= s_clk;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
      if (!s_prst) begin
        // port reset wins over everything, including a commit or fetch in flight
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        rdrdy_q  <= 1'b0;
        rddata_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (rise) begin
            if (s_wr && s_rd) begin
              err_q   <= 1'b1;
              state_q <= S_WAIT;
            end else if (s_wr) begin
              sh_q    <= sh_d;
              cnt_q   <= CW'(1);
              state_q <= S_WR_SHIFT;
            end else if (s_rd) begin
              sh_q    <= sh_d;
              cnt_q   <= CW'(1);
              state_q <= S_RD_ADDR;
            end
          end
          S_WR_SHIFT: begin
            if (!s_wr) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_d;
              if (cnt_d == CW'(FW)) begin
                wr_en_q <= 1'b1;
                addr_q  <= sh_d[FW-1:DATA_W];
                wdata_q <= sh_d[DATA_W-1:0];
                state_q <= S_WR_COMMIT;
              end
            end
          end
          S_WR_COMMIT: state_q <= S_WAIT;
          S_RD_ADDR: begin
            if (!s_rd) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_d;
              if (cnt_d == CW'(ADDR_W)) begin
                rd_en_q <= 1'b1;
                addr_q  <= sh_d[ADDR_W-1:0];
                state_q <= S_RD_FETCH;
              end
            end
          end
          S_RD_FETCH: state_q <= S_RD_LOAD;
          S_RD_LOAD: begin
            out_q    <= reg_rd_data;
            rdrdy_q  <= 1'b1;
            rddata_q <= reg_rd_data[DATA_W-1];
            cnt_q    <= '0;
            state_q  <= S_RD_SHIFT;
          end
          S_RD_SHIFT: begin
            if (!s_rd) begin
              rdrdy_q  <= 1'b0;
              rddata_q <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= S_IDLE;
            end else if (rise) begin
              cnt_q <= cnt_d;
              if (cnt_d == CW'(DATA_W)) begin
                rdrdy_q  <= 1'b0;
                rddata_q <= 1'b0;
                state_q  <= S_WAIT;
              end else begin
                out_q    <= {out_q[DATA_W-2:0], 1'b0};
                rddata_q <= out_q[DATA_W-2];
              end
            end
          end
          S_WAIT: if (!s_wr && !s_rd) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign PINT_RDRDY  = rdrdy_q;
  assign PINT_RDDATA = rddata_q;
  assign reg_addr    = addr_q;
  assign reg_wr_data = wdata_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign frame_err   = err_q;

endmodule
